// File: rtl/nes_poll_scheduler.sv
// ============================================================================
// Module  : nes_poll_scheduler
// Brief   : Two-port NES controller poller sharing one latch/clock pair, with
//           valid/ack result delivery. Optional macro NES_EDGE_DETECT_EN adds
//           per-pad newly-pressed outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_poll_scheduler #(
    parameter int CLK_DIV     = 600,
    parameter int POLL_PERIOD = 833333
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       poll_req,
    output logic       busy,
    output logic       data_latch,
    output logic       data_clock,
    input  logic [1:0] serial_data,
    output logic [7:0] pad0_state,
    output logic [7:0] pad1_state,
    output logic       state_valid,
    input  logic       state_ack,
    output logic       overrun
`ifdef NES_EDGE_DETECT_EN
    ,
    output logic [7:0] pad0_pressed,
    output logic [7:0] pad1_pressed
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [TMR_W-1:0] poll_timer;
    logic             timer_wrap;
    logic             pending;
    logic             latch_half;
    logic             read_half;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift0;
    logic [7:0]       shift1;

    assign busy       = (state != ST_IDLE);
    assign tick       = busy && (div == DIV_LAST);
    assign timer_wrap = enable && (poll_timer == TMR_LAST);

    always_ff @(posedge master_clock) begin
        if (reset) begin
            poll_timer <= '0;
        end else if (!enable || timer_wrap) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + 1'b1;
        end
    end

    // Requests arriving while a poll is pending or running collapse into one.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending && (state != ST_IDLE)) || poll_req || timer_wrap;
        end
    end

    // Divider sits at zero in IDLE, so entry to LATCH always starts a full period.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            div <= '0;
        end else if (!busy || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            data_latch  <= 1'b0;
            data_clock  <= 1'b0;
            latch_half  <= 1'b0;
            read_half   <= 1'b0;
            bit_cnt     <= 3'd0;
            shift0      <= 8'd0;
            shift1      <= 8'd0;
            pad0_state  <= 8'd0;
            pad1_state  <= 8'd0;
            state_valid <= 1'b0;
            overrun     <= 1'b0;
`ifdef NES_EDGE_DETECT_EN
            pad0_pressed <= 8'd0;
            pad1_pressed <= 8'd0;
`endif
        end else begin
            overrun <= 1'b0;
            if (state_ack) begin
                state_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state      <= ST_LATCH;
                        data_latch <= 1'b1;
                        latch_half <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        if (latch_half) begin
                            state      <= ST_READ;
                            data_latch <= 1'b0;
                            bit_cnt    <= 3'd0;
                            read_half  <= 1'b0;
                        end else begin
                            latch_half <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (tick) begin
                        if (!read_half) begin
                            // Lines are active-low; first bit ends up in bit 7.
                            shift0     <= {shift0[6:0], ~serial_data[0]};
                            shift1     <= {shift1[6:0], ~serial_data[1]};
                            data_clock <= 1'b1;
                            read_half  <= 1'b1;
                        end else begin
                            data_clock <= 1'b0;
                            read_half  <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    pad0_state  <= shift0;
                    pad1_state  <= shift1;
                    state_valid <= 1'b1;
                    overrun     <= state_valid && !state_ack;
`ifdef NES_EDGE_DETECT_EN
                    pad0_pressed <= shift0 & ~pad0_state;
                    pad1_pressed <= shift1 & ~pad1_state;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
